// File: rtl/mc_pkg.sv
// Shared multicycle-controller definitions: control-word bit positions,
// memory-stage FSM state codes and read-destination encoding.
package mc_pkg;

    localparam int MEMREAD  = 16;
    localparam int MEMWRITE = 15;
    localparam int IRWRITE  = 14;
    localparam int INSTDATA = 17;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
    typedef enum logic {DEST_IR = 1'b0, DEST_DATA = 1'b1} dest_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// Word-memory request/ack bus between the memory-access stage (master)
// and the memory (slave).
interface mem_access_unit_if #(
    parameter int DATA_W = 32,
    parameter int MEM_AW = 10
);
    logic              mem_req_o;
    logic              mem_we_o;
    logic [MEM_AW-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_ack_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i, mem_ack_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i, mem_ack_i
    );
endinterface

// File: rtl/mem_wdog.sv
// BUSY-phase watchdog: counts BUSY cycles from entry and flags the cycle
// in which the TIMEOUT_CYC-th BUSY cycle is reached.
module mem_wdog #(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic hit
);
    logic [3:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  cnt <= '0;
        else if (clr)  cnt <= '0;
        else if (en)   cnt <= cnt + 4'd1;
    end

    // cnt is 0 in the first BUSY cycle, so the last allowed cycle sees TIMEOUT_CYC-1
    assign hit = en && (cnt == 4'(TIMEOUT_CYC - 1));
endmodule

// File: rtl/mem_access_unit.sv
// Memory-side stage of the multicycle controller: one req/ack access per
// MemRead/MemWrite, loading IR or the data register. Watchdog abort is
// built only when MEM_TIMEOUT_EN is defined.
module mem_access_unit
    import mc_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int MEM_AW      = 10,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   mem_read_i,
    input  logic                   mem_write_i,
    input  logic                   inst_data_i,
    input  logic                   ir_write_i,
    input  logic [DATA_W-1:0]      pc_i,
    input  logic [DATA_W-1:0]      z_i,
    input  logic [DATA_W-1:0]      y_i,
    mem_access_unit_if.master      mem,
    output logic [DATA_W-1:0]      ir_o,
    output logic [5:0]             op_o,
    output logic [5:0]             funct_o,
    output logic [DATA_W-1:0]      data_o,
    output logic                   stall_o,
    output logic                   proto_err_o,
    output logic                   timeout_o
);
    state_t            state, nextState;
    dest_t             dest;
    logic              start, expire;
    logic              req, reqWe;
    logic [MEM_AW-1:0] reqAddr;
    logic [DATA_W-1:0] reqWdata, selAddr, irReg, dataReg;
    logic              protoErr;
    logic              unusedAddrBits;

    assign selAddr        = inst_data_i ? z_i : pc_i;
    assign unusedAddrBits = ^{selAddr[DATA_W-1:MEM_AW+2], selAddr[1:0]};

    always_comb begin
        nextState = state;
        start     = 1'b0;
        stall_o   = 1'b0;
        case (state)
            IDLE: if (mem_read_i || mem_write_i) begin
                start     = 1'b1;
                stall_o   = 1'b1;
                nextState = BUSY;
            end
            BUSY: if (mem.mem_ack_i || expire) nextState = IDLE;
                  else stall_o = 1'b1;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            req      <= 1'b0;
            reqWe    <= 1'b0;
            reqAddr  <= '0;
            reqWdata <= '0;
            dest     <= DEST_IR;
            irReg    <= '0;
            dataReg  <= '0;
            protoErr <= 1'b0;
        end else begin
            state <= nextState;
            req   <= (nextState == BUSY);
            if (start) begin
                reqAddr  <= selAddr[MEM_AW+1:2];
                reqWe    <= mem_write_i && !mem_read_i;
                reqWdata <= y_i;
                dest     <= ir_write_i ? DEST_IR : DEST_DATA;
                if (mem_read_i && mem_write_i) protoErr <= 1'b1;
            end
            if (state == BUSY && mem.mem_ack_i && !reqWe) begin
                if (dest == DEST_IR) irReg   <= mem.mem_rdata_i;
                else                 dataReg <= mem.mem_rdata_i;
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    logic wdogHit, timeoutFlag;

    mem_wdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) uWdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (start),
        .en      (state == BUSY),
        .hit     (wdogHit)
    );

    // a late ack on the expiry cycle still completes the access
    assign expire = wdogHit && !mem.mem_ack_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    timeoutFlag <= 1'b0;
        else if (expire) timeoutFlag <= 1'b1;
    end
    assign timeout_o = timeoutFlag;
`else
    localparam int unusedTimeoutCyc = TIMEOUT_CYC;
    assign expire    = 1'b0;
    assign timeout_o = 1'b0;
`endif

    assign mem.mem_req_o   = req;
    assign mem.mem_we_o    = reqWe;
    assign mem.mem_addr_o  = reqAddr;
    assign mem.mem_wdata_o = reqWdata;
    assign ir_o            = irReg;
    assign op_o            = irReg[31:26];
    assign funct_o         = irReg[5:0];
    assign data_o          = dataReg;
    assign proto_err_o     = protoErr;
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit; the watchdog scenario runs when
// MEM_TIMEOUT_EN is defined, otherwise a long wait checks there is no abort.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        mem_read_i = 1'b0, mem_write_i = 1'b0;
    logic        inst_data_i = 1'b0, ir_write_i = 1'b0;
    logic [31:0] pc_i = '0, z_i = '0, y_i = '0;
    logic [31:0] ir_o, data_o;
    logic [5:0]  op_o, funct_o;
    logic        stall_o, proto_err_o, timeout_o;

    typedef struct packed {logic toIr; logic [31:0] val;} sbEntry_t;
    sbEntry_t    sb[$];
    logic [31:0] expIr = '0, expData = '0;
    int          nChecks = 0, nFail = 0;

    mem_access_unit_if #(.DATA_W(32), .MEM_AW(10)) mem ();

    mem_access_unit #(.DATA_W(32), .MEM_AW(10), .TIMEOUT_CYC(15)) dut (
        .clk(clk), .reset_n(reset_n),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .inst_data_i(inst_data_i), .ir_write_i(ir_write_i),
        .pc_i(pc_i), .z_i(z_i), .y_i(y_i), .mem(mem),
        .ir_o(ir_o), .op_o(op_o), .funct_o(funct_o), .data_o(data_o),
        .stall_o(stall_o), .proto_err_o(proto_err_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic chkRegs(input string tag);
        chk({tag, ":ir"}, ir_o, expIr);
        chk({tag, ":op"}, 32'(op_o), 32'(expIr[31:26]));
        chk({tag, ":funct"}, 32'(funct_o), 32'(expIr[5:0]));
        chk({tag, ":data"}, data_o, expData);
    endtask

    // One access; ack arrives in the busy-th BUSY cycle, so the access spans 1+busy cycles.
    task automatic access(input string tag, input logic rd, input logic wr, input logic instData,
                          input logic irWr, input logic [31:0] byteAddr, input logic [31:0] y,
                          input logic [31:0] rdata, input int busy);
        logic [31:0] expAddr;
        logic        expWe;
        sbEntry_t    e;
        expAddr = 32'(byteAddr[11:2]);
        expWe   = wr & ~rd;
        if (rd) sb.push_back('{irWr, rdata});
        @(negedge clk);
        mem_read_i = rd; mem_write_i = wr; inst_data_i = instData; ir_write_i = irWr;
        if (instData) begin z_i = byteAddr; pc_i = $urandom; end
        else          begin pc_i = byteAddr; z_i = $urandom; end
        y_i = y;
        #1 chk({tag, ":stallReq"}, 32'(stall_o), 32'd1);
        @(posedge clk); #1;
        mem_read_i = 1'b0; mem_write_i = 1'b0;
        pc_i = $urandom; z_i = $urandom; y_i = $urandom;
        inst_data_i = 1'($urandom); ir_write_i = 1'($urandom);
        for (int c = 1; c <= busy; c++) begin
            @(negedge clk);
            if (c == busy) begin mem.mem_ack_i = 1'b1; mem.mem_rdata_i = rdata; end
            #1;
            chk({tag, ":req"},   32'(mem.mem_req_o), 32'd1);
            chk({tag, ":addr"},  32'(mem.mem_addr_o), expAddr);
            chk({tag, ":we"},    32'(mem.mem_we_o), 32'(expWe));
            chk({tag, ":wdata"}, mem.mem_wdata_o, y);
            chk({tag, ":stall"}, 32'(stall_o), (c == busy) ? 32'd0 : 32'd1);
        end
        @(posedge clk); #1;
        mem.mem_ack_i = 1'b0; mem.mem_rdata_i = $urandom;
        @(negedge clk);
        chk({tag, ":reqDone"},   32'(mem.mem_req_o), 32'd0);
        chk({tag, ":stallDone"}, 32'(stall_o), 32'd0);
        if (rd) begin
            if (sb.size() == 0) chk({tag, ":sbEmpty"}, 32'd1, 32'd0);
            else begin
                e = sb.pop_front();
                if (e.toIr) expIr = e.val; else expData = e.val;
            end
        end
        chkRegs(tag);
    endtask

    initial begin
        mem.mem_ack_i = 1'b0; mem.mem_rdata_i = '0;
        #12;
        chk("rst:req", 32'(mem.mem_req_o), 32'd0);
        chk("rst:we", 32'(mem.mem_we_o), 32'd0);
        chk("rst:addr", 32'(mem.mem_addr_o), 32'd0);
        chk("rst:wdata", mem.mem_wdata_o, 32'd0);
        chk("rst:proto", 32'(proto_err_o), 32'd0);
        chk("rst:timeout", 32'(timeout_o), 32'd0);
        chkRegs("rst");
        @(negedge clk); reset_n = 1'b1;

        // ack in IDLE must not load anything
        @(negedge clk); mem.mem_ack_i = 1'b1; mem.mem_rdata_i = 32'hDEAD_BEEF;
        @(negedge clk); mem.mem_ack_i = 1'b0;
        chk("idleAck:req", 32'(mem.mem_req_o), 32'd0);
        chkRegs("idleAck");

        access("fetch",  1, 0, 0, 1, 32'h40,  32'h5555, 32'h012A_5820, 1);
        chk("fetch:op", 32'(op_o), 32'd0);
        chk("fetch:funct", 32'(funct_o), 32'h20);
        access("lw",     1, 0, 1, 0, 32'h104, 32'h7777, 32'hCAFE_F00D, 3);
        access("sw",     0, 1, 1, 0, 32'h8,   32'h1234, 32'hBAD0_BAD0, 2);
        access("rdwr",   1, 1, 1, 0, 32'h20,  32'h9999, 32'h0BAD_CAFE, 1);
        chk("rdwr:proto", 32'(proto_err_o), 32'd1);
        access("unalign", 1, 0, 0, 1, 32'h43, 32'h0, 32'h8C43_0004, 2);
        chk("unalign:protoSticky", 32'(proto_err_o), 32'd1);

        // async reset in the middle of an access
        @(negedge clk); mem_read_i = 1'b1; ir_write_i = 1'b1; inst_data_i = 1'b0; pc_i = 32'h80;
        @(posedge clk); #1 mem_read_i = 1'b0;
        @(posedge clk); #3 reset_n = 1'b0;
        #1;
        chk("midRst:req", 32'(mem.mem_req_o), 32'd0);
        chk("midRst:addr", 32'(mem.mem_addr_o), 32'd0);
        chk("midRst:proto", 32'(proto_err_o), 32'd0);
        chk("midRst:stall", 32'(stall_o), 32'd0);
        expIr = '0; expData = '0;
        chkRegs("midRst");
        @(negedge clk); reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("postRst:req", 32'(mem.mem_req_o), 32'd0);
        end

`ifdef MEM_TIMEOUT_EN
        access("pre", 1, 0, 0, 1, 32'h100, 32'h0, 32'h2000_0001, 1);
        @(negedge clk); mem_read_i = 1'b1; ir_write_i = 1'b1; pc_i = 32'h200;
        @(posedge clk); #1 mem_read_i = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            chk("wdog:req", 32'(mem.mem_req_o), 32'd1);
            chk("wdog:stall", 32'(stall_o), (c == 15) ? 32'd0 : 32'd1);
        end
        @(negedge clk);
        chk("wdog:reqDrop", 32'(mem.mem_req_o), 32'd0);
        chk("wdog:timeout", 32'(timeout_o), 32'd1);
        chkRegs("wdog");
        access("afterWdog", 1, 0, 1, 0, 32'h44, 32'h0, 32'h1357_9BDF, 2);
        chk("afterWdog:timeout", 32'(timeout_o), 32'd1);
`else
        access("slow", 1, 0, 0, 1, 32'h100, 32'h0, 32'h2000_0001, 20);
        chk("slow:timeout", 32'(timeout_o), 32'd0);
`endif

        chk("sb:drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
